// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator.
// Contents: the FSM state enum, the bit positions inside the sticky err output,
// and the bias loader output latency.
// Optional feature macro: PSUM_ACC_SAT_EN. When it is defined, adds saturate and err is 3 bits wide.
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitBias,
    StAccum,
    StDrain
  } state_e;

  // Bit positions inside err.
  localparam int unsigned ERR_BAD_ROWS = 0;  // tile_rows was 0 or larger than DEPTH
  localparam int unsigned ERR_PASS_LEN = 1;  // pass beat count differed from tile_rows
  localparam int unsigned ERR_SAT      = 2;  // saturation occurred (saturating build only)

`ifdef PSUM_ACC_SAT_EN
  localparam int unsigned ERR_W = 3;
`else
  localparam int unsigned ERR_W = 2;
`endif

  // Cycles from the pass start until bias loader data_out is valid.
  localparam int unsigned BIAS_LAT = 2;

endpackage

// File: rtl/psum_acc_bank.sv
// Accumulator row bank: a DEPTH x SIZE register array.
// It has one combinational read port and one synchronous write port.
// There is no reset because the bank contents are don't-care until a pass writes them.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write row
//   wdata  write row data
//   raddr  read row
//   rdata  read row data (combinational)
module psum_acc_bank #(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [ADDR_W-1:0]               waddr,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]               raddr,
  output logic [SIZE-1:0][DATA_WIDTH-1:0] rdata
);

  logic [SIZE-1:0][DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator for one OA tile.
// - Captures the bias vector at the start of each pass.
// - Accumulates psum rows across all IA/W passes. The first pass stores bias + psum.
// - On OA tile end, drains the finished rows over a valid/ready stream.
// Optional feature macro: PSUM_ACC_SAT_EN. It enables saturating adds and adds err[2].
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   init_cfg, tile_rows      latch the row count and abort any activity
//   tile_calc_start          pass start (rising edge)
//   partial_sum_calc_over    pass end (rising edge)
//   tile_calc_over           OA tile end (rising edge)
//   bias_in                  bias loader output vector
//   psum_valid/ready/data    psum row input stream
//   oa_valid/ready/data/last drained row output stream
//   busy                     FSM not idle
//   err                      sticky errors: [0] bad tile_rows, [1] pass length, [2] saturation
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned REG_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            init_cfg,
  input  logic [REG_WIDTH-1:0]            tile_rows,
  input  logic                            tile_calc_start,
  input  logic                            partial_sum_calc_over,
  input  logic                            tile_calc_over,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0] bias_in,
  input  logic                            psum_valid,
  output logic                            psum_ready,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0] psum_data,
  output logic                            oa_valid,
  input  logic                            oa_ready,
  output logic [SIZE-1:0][DATA_WIDTH-1:0] oa_data,
  output logic                            oa_last,
  output logic                            busy,
  output logic [ERR_W-1:0]                err
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = AddrW + 2;
  localparam int unsigned WaitW = (BIAS_LAT > 2) ? $clog2(BIAS_LAT) : 1;

  typedef logic [SIZE-1:0][DATA_WIDTH-1:0] row_t;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [AddrW-1:0] row_cnt_q, row_cnt_d;
  logic [AddrW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AddrW-1:0] rows_m1_q, rows_m1_d;
  logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
  logic             first_pass_q, first_pass_d;
  logic             start_pend_q, start_pend_d;
  logic             over_pend_q, over_pend_d;
  row_t             bias_q, bias_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic start_in_q, ps_over_in_q, tile_over_in_q;
  logic start_p, ps_over_p, tile_over_p;
  logic psum_hs, oa_hs, bank_we;
  logic [AddrW-1:0] rd_addr;
  row_t rd_row, addend, wr_row;

  assign start_p     = tile_calc_start & ~start_in_q;
  assign ps_over_p   = partial_sum_calc_over & ~ps_over_in_q;
  assign tile_over_p = tile_calc_over & ~tile_over_in_q;

  assign psum_hs = psum_valid & psum_ready;
  assign oa_hs   = oa_valid & oa_ready;

  // Only one of accumulate/drain is active, so a single read port serves both.
  assign rd_addr = (state_q == StDrain) ? rd_cnt_q : row_cnt_q;

`ifdef PSUM_ACC_SAT_EN
  logic [DATA_WIDTH:0] wide [SIZE];
  logic [SIZE-1:0]     lane_sat;
  logic                sat_any;

  always_comb begin
    for (int l = 0; l < SIZE; l++) begin
      addend[l] = first_pass_q ? bias_q[l] : rd_row[l];
      wide[l] = {addend[l][DATA_WIDTH-1], addend[l]} +
                {psum_data[l][DATA_WIDTH-1], psum_data[l]};
      // Overflow when the extra sign bit disagrees with the result sign.
      lane_sat[l] = wide[l][DATA_WIDTH] ^ wide[l][DATA_WIDTH-1];
      wr_row[l] = lane_sat[l] ? {wide[l][DATA_WIDTH], {(DATA_WIDTH-1){~wide[l][DATA_WIDTH]}}}
                              : wide[l][DATA_WIDTH-1:0];
    end
  end
  assign sat_any = |lane_sat;
`else
  always_comb begin
    for (int l = 0; l < SIZE; l++) begin
      addend[l] = first_pass_q ? bias_q[l] : rd_row[l];
      wr_row[l] = addend[l] + psum_data[l];
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    row_cnt_d    = row_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rows_m1_d    = rows_m1_q;
    beat_cnt_d   = beat_cnt_q;
    first_pass_d = first_pass_q;
    start_pend_d = start_pend_q;
    over_pend_d  = over_pend_q;
    bias_d       = bias_q;
    err_d        = err_q;
    bank_we      = 1'b0;

    if (init_cfg) begin
      state_d      = StIdle;
      wait_cnt_d   = '0;
      row_cnt_d    = '0;
      rd_cnt_d     = '0;
      beat_cnt_d   = '0;
      first_pass_d = 1'b1;
      start_pend_d = 1'b0;
      over_pend_d  = 1'b0;
      err_d[ERR_PASS_LEN] = 1'b0;
      if (tile_rows == '0) begin
        err_d[ERR_BAD_ROWS] = 1'b1;
        rows_m1_d = '0;
      end else if (tile_rows > REG_WIDTH'(DEPTH)) begin
        err_d[ERR_BAD_ROWS] = 1'b1;
        rows_m1_d = AddrW'(DEPTH - 1);
      end else begin
        rows_m1_d = AddrW'(tile_rows - 1'b1);
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // A pending drain takes precedence over a pending start.
          if (tile_over_p || over_pend_q) begin
            state_d     = StDrain;
            rd_cnt_d    = '0;
            over_pend_d = 1'b0;
            if (start_p) start_pend_d = 1'b1;
          end else if (start_p || start_pend_q) begin
            state_d      = StWaitBias;
            wait_cnt_d   = '0;
            start_pend_d = 1'b0;
          end
        end
        StWaitBias: begin
          if (start_p) start_pend_d = 1'b1;
          if (tile_over_p) over_pend_d = 1'b1;
          if (wait_cnt_q == WaitW'(BIAS_LAT - 1)) begin
            bias_d     = bias_in;
            state_d    = StAccum;
            beat_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        StAccum: begin
          if (psum_hs) begin
            bank_we   = 1'b1;
            row_cnt_d = (row_cnt_q == rows_m1_q) ? '0 : row_cnt_q + 1'b1;
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
          end
          // beat_cnt_d already includes a handshake in this same cycle.
          if (ps_over_p) begin
            if (beat_cnt_d != (CntW'(rows_m1_q) + 1'b1)) err_d[ERR_PASS_LEN] = 1'b1;
            row_cnt_d    = '0;
            first_pass_d = 1'b0;
            if (tile_over_p) begin
              state_d  = StDrain;
              rd_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else if (tile_over_p) begin
            over_pend_d = 1'b1;
          end
        end
        StDrain: begin
          if (start_p) start_pend_d = 1'b1;
          if (tile_over_p) over_pend_d = 1'b1;
          if (oa_hs) begin
            if (rd_cnt_q == rows_m1_q) begin
              state_d      = StIdle;
              rd_cnt_d     = '0;
              first_pass_d = 1'b1;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

`ifdef PSUM_ACC_SAT_EN
    if (bank_we && sat_any) err_d[ERR_SAT] = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      wait_cnt_q     <= '0;
      row_cnt_q      <= '0;
      rd_cnt_q       <= '0;
      rows_m1_q      <= AddrW'(DEPTH - 1);
      beat_cnt_q     <= '0;
      first_pass_q   <= 1'b1;
      start_pend_q   <= 1'b0;
      over_pend_q    <= 1'b0;
      bias_q         <= '0;
      err_q          <= '0;
      start_in_q     <= 1'b0;
      ps_over_in_q   <= 1'b0;
      tile_over_in_q <= 1'b0;
      psum_ready     <= 1'b0;
      oa_valid       <= 1'b0;
      oa_last        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      row_cnt_q      <= row_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      rows_m1_q      <= rows_m1_d;
      beat_cnt_q     <= beat_cnt_d;
      first_pass_q   <= first_pass_d;
      start_pend_q   <= start_pend_d;
      over_pend_q    <= over_pend_d;
      bias_q         <= bias_d;
      err_q          <= err_d;
      start_in_q     <= tile_calc_start;
      ps_over_in_q   <= partial_sum_calc_over;
      tile_over_in_q <= tile_calc_over;
      // Outputs are registered from the next state so they line up with state_q.
      psum_ready     <= (state_d == StAccum);
      oa_valid       <= (state_d == StDrain);
      oa_last        <= (state_d == StDrain) && (rd_cnt_d == rows_m1_d);
      busy           <= (state_d != StIdle);
    end
  end

  psum_acc_bank #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (AddrW)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (row_cnt_q),
    .wdata (wr_row),
    .raddr (rd_addr),
    .rdata (rd_row)
  );

  assign oa_data = oa_valid ? rd_row : '0;
  assign err     = err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator.
// The reference model holds the bank as plain per-row lane arrays.
// It applies bias/psum arithmetic per beat and queues each tile's rows when the tile ends.
// A separate monitor pops the queue on every oa handshake.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  localparam int SIZE  = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int RW    = 32;

  typedef logic [SIZE-1:0][DW-1:0] row_t;
  typedef struct {
    row_t data;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_cfg = 1'b0;
  logic [RW-1:0] tile_rows = '0;
  logic tile_calc_start = 1'b0;
  logic partial_sum_calc_over = 1'b0;
  logic tile_calc_over = 1'b0;
  row_t bias_in = '0;
  logic psum_valid = 1'b0;
  logic psum_ready;
  row_t psum_data = '0;
  logic oa_valid;
  logic oa_ready = 1'b0;
  row_t oa_data;
  logic oa_last;
  logic busy;
  logic [ERR_W-1:0] err;

  always #5 clk = ~clk;

  psum_accumulator #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .REG_WIDTH  (RW)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .init_cfg              (init_cfg),
    .tile_rows             (tile_rows),
    .tile_calc_start       (tile_calc_start),
    .partial_sum_calc_over (partial_sum_calc_over),
    .tile_calc_over        (tile_calc_over),
    .bias_in               (bias_in),
    .psum_valid            (psum_valid),
    .psum_ready            (psum_ready),
    .psum_data             (psum_data),
    .oa_valid              (oa_valid),
    .oa_ready              (oa_ready),
    .oa_data               (oa_data),
    .oa_last               (oa_last),
    .busy                  (busy),
    .err                   (err)
  );

  int n_checks = 0;
  int n_errs = 0;

  // Reference model state.
  exp_t exp_q[$];
  row_t bank_m [DEPTH];
  row_t bias_m;
  int   rows_m = DEPTH;
  int   beats_m = 0;
  bit   first_m = 1'b1;
  bit   sat_m;
  logic [ERR_W-1:0] err_m = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] add_m(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef PSUM_ACC_SAT_EN
    if (s > 64'sd2147483647) begin
      sat_m = 1'b1;
      return 32'h7fff_ffff;
    end
    if (s < -64'sd2147483648) begin
      sat_m = 1'b1;
      return 32'h8000_0000;
    end
`endif
    return s[31:0];
  endfunction

  function automatic row_t add_row(input row_t a, input row_t b);
    row_t r;
    for (int l = 0; l < SIZE; l++) r[l] = add_m(a[l], b[l]);
    return r;
  endfunction

  function automatic row_t fill(input logic [31:0] v);
    row_t r;
    for (int l = 0; l < SIZE; l++) r[l] = v;
    return r;
  endfunction

  function automatic row_t rnd_row();
    row_t r;
    for (int l = 0; l < SIZE; l++) r[l] = $urandom();
    return r;
  endfunction

  task automatic do_init(input int unsigned rows);
    tile_rows = rows;
    init_cfg = 1'b1;
    tick();
    init_cfg = 1'b0;
    if (rows == 0) begin
      rows_m = 1;
      err_m[ERR_BAD_ROWS] = 1'b1;
    end else if (rows > DEPTH) begin
      rows_m = DEPTH;
      err_m[ERR_BAD_ROWS] = 1'b1;
    end else begin
      rows_m = int'(rows);
    end
    err_m[ERR_PASS_LEN] = 1'b0;
    first_m = 1'b1;
    beats_m = 0;
    tick();
  endtask

  // Counts cycles until psum_ready; the spec latency from the start event is 3.
  task automatic wait_ready(input int start_n, input string name);
    int n = start_n;
    while (!psum_ready && n < 30) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'd3);
  endtask

  task automatic start_pass(input row_t b);
    bias_in = b;
    bias_m = b;
    tile_calc_start = 1'b1;
    tick();
    tile_calc_start = 1'b0;
    wait_ready(1, "psum_ready latency");
  endtask

  task automatic send_row(input row_t p);
    int guard = 0;
    bit hs = 1'b0;
    int r;
    repeat ($urandom_range(0, 2)) tick();
    psum_data = p;
    psum_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = psum_ready;
      tick();
      guard++;
    end while (!hs && guard < 50);
    psum_valid = 1'b0;
    if (!hs) begin
      n_checks++;
      n_errs++;
      $display("FAIL psum handshake timeout: got ready=0 expected ready=1");
    end else begin
      r = beats_m % rows_m;
      sat_m = 1'b0;
      bank_m[r] = add_row(first_m ? bias_m : bank_m[r], p);
`ifdef PSUM_ACC_SAT_EN
      if (sat_m) err_m[ERR_SAT] = 1'b1;
`endif
      beats_m++;
    end
  endtask

  task automatic push_tile();
    exp_t e;
    for (int r = 0; r < rows_m; r++) begin
      e.data = bank_m[r];
      e.last = (r == rows_m - 1);
      exp_q.push_back(e);
    end
    first_m = 1'b1;
  endtask

  task automatic end_pass(input bit with_tile);
    partial_sum_calc_over = 1'b1;
    if (with_tile) tile_calc_over = 1'b1;
    tick();
    partial_sum_calc_over = 1'b0;
    tile_calc_over = 1'b0;
    if (beats_m != rows_m) err_m[ERR_PASS_LEN] = 1'b1;
    first_m = 1'b0;
    beats_m = 0;
    if (with_tile) push_tile();
    tick();
  endtask

  // mode 0: always ready, 1: pattern 1,0,0,1, 2: random. start_at >= 0 pulses start mid-drain.
  task automatic drain(input int mode, input int start_at, input bit pulse_tile);
    int idx = 0;
    int guard = 0;
    logic [3:0] pat;
    pat = 4'b1001;
    if (pulse_tile) begin
      tile_calc_over = 1'b1;
      tick();
      tile_calc_over = 1'b0;
      push_tile();
    end
    while (exp_q.size() != 0 && guard < 300) begin
      tile_calc_start = 1'b0;
      if (oa_valid) begin
        case (mode)
          0: oa_ready = 1'b1;
          1: oa_ready = pat[3 - (idx % 4)];
          default: oa_ready = 1'($urandom_range(0, 1));
        endcase
        if (idx == start_at) tile_calc_start = 1'b1;
        idx++;
      end
      tick();
      guard++;
    end
    tile_calc_start = 1'b0;
    oa_ready = 1'b0;
    check("drain completes", 64'(exp_q.size()), 64'd0);
    check("oa_valid after drain", 64'(oa_valid), 64'd0);
  endtask

  // Monitor: compares each drained row against the scoreboard and checks stall stability.
  initial begin : monitor
    row_t prev;
    bit stalled;
    exp_t e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && oa_valid) begin
        if (stalled) begin
          n_checks++;
          if (oa_data !== prev) begin
            n_errs++;
            $display("FAIL oa_data stall stability: got %h expected %h", oa_data, prev);
          end
        end
        if (oa_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL unexpected oa row: got %h expected none", oa_data);
          end else begin
            e = exp_q.pop_front();
            if (oa_data !== e.data || oa_last !== e.last) begin
              n_errs++;
              $display("FAIL oa row: got %h last=%b expected %h last=%b",
                       oa_data, oa_last, e.data, e.last);
            end
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = oa_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int rows;
    int np;
    bit both;
    repeat (3) @(posedge clk);
    #1;
    check("reset psum_ready", 64'(psum_ready), 64'd0);
    check("reset oa_valid", 64'(oa_valid), 64'd0);
    check("reset oa_last", 64'(oa_last), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset oa_data", 64'(|oa_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single pass: bias 10, psum 1..4 -> 11..14.
    do_init(4);
    start_pass(fill(32'd10));
    check("busy in pass", 64'(busy), 64'd1);
    for (int r = 0; r < 4; r++) send_row(fill(32'(r + 1)));
    end_pass(1'b0);
    drain(0, -1, 1'b1);
    check("err single pass", 64'(err), 64'(err_m));

    // Three passes: bias 5 then 0, psum 2 -> 11.
    do_init(4);
    for (int p = 0; p < 3; p++) begin
      start_pass(fill(p == 0 ? 32'd5 : 32'd0));
      for (int r = 0; r < 4; r++) send_row(fill(32'd2));
      end_pass(1'b0);
    end
    drain(0, -1, 1'b1);
    check("err three passes", 64'(err), 64'd0);

    // Backpressure with ready 1,0,0,1.
    do_init(4);
    start_pass(rnd_row());
    for (int r = 0; r < 4; r++) send_row(rnd_row());
    end_pass(1'b0);
    drain(1, -1, 1'b1);

    // Short pass sets err[1]; init clears it.
    do_init(4);
    start_pass(rnd_row());
    for (int r = 0; r < 3; r++) send_row(rnd_row());
    end_pass(1'b0);
    check("err short pass", 64'(err), 64'(err_m));
    do_init(4);
    check("err after init", 64'(err), 64'(err_m));

    // Saturation boundary.
    do_init(1);
    start_pass(fill(32'h7fff_fff0));
    send_row(fill(32'h0000_0020));
    end_pass(1'b1);
    drain(0, -1, 1'b0);
    check("err after large add", 64'(err), 64'(err_m));
    do_init(1);

    // Start pulsed mid-drain is serviced after the last row.
    do_init(4);
    start_pass(rnd_row());
    for (int r = 0; r < 4; r++) send_row(rnd_row());
    end_pass(1'b0);
    bias_in = rnd_row();
    bias_m = bias_in;
    drain(2, 1, 1'b1);
    wait_ready(0, "pending start latency");
    for (int r = 0; r < 4; r++) send_row(rnd_row());
    end_pass(1'b1);
    drain(0, -1, 1'b0);

    // Randomized tiles, including simultaneous pass end and tile end.
    for (int t = 0; t < 6; t++) begin
      rows = $urandom_range(1, DEPTH);
      np = $urandom_range(1, 3);
      do_init(rows);
      for (int p = 0; p < np; p++) begin
        start_pass(rnd_row());
        for (int r = 0; r < rows; r++) send_row(rnd_row());
        both = (p == np - 1) && ($urandom_range(0, 1) == 1);
        end_pass(both);
      end
      drain(2, -1, !both);
      check("err random tile", 64'(err), 64'(err_m));
    end

    // Illegal tile_rows: 0 clamps to 1, 20 clamps to DEPTH; err[0] sticky.
    do_init(0);
    check("err rows 0", 64'(err), 64'(err_m));
    start_pass(rnd_row());
    send_row(rnd_row());
    end_pass(1'b1);
    drain(2, -1, 1'b0);
    do_init(20);
    start_pass(rnd_row());
    for (int r = 0; r < DEPTH; r++) send_row(rnd_row());
    end_pass(1'b0);
    drain(2, -1, 1'b1);
    check("err rows 20", 64'(err), 64'(err_m));

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
